// File: rtl/wb_sram_responder_pkg.sv
// ------------------------------------------------------------------------------------
// rvj1_wb_pkg : shared types and constants for the Wishbone SRAM responder.  Rev 1.0
// ------------------------------------------------------------------------------------
`default_nettype none

package rvj1_wb_pkg;

  localparam int unsigned WB_DAT_W     = 32;
  localparam int unsigned WB_SEL_W     = 4;
  localparam int unsigned SRAM_WMASK_W = 4;
  localparam logic [WB_DAT_W-1:0] MISS_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_e;

  // True when adr lies in the naturally aligned window of 2^lsb bytes starting at base.
  function automatic logic window_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned lsb);
    return (adr >> lsb) == (base >> lsb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sram_responder_if.sv
// ------------------------------------------------------------------------------------
// wb_sram_responder_if : Wishbone classic slave-side bus bundle.  Rev 1.0
// ------------------------------------------------------------------------------------
`default_nettype none

interface wb_sram_responder_if;
  import rvj1_wb_pkg::*;

  logic                wbs_cyc_i;
  logic                wbs_stb_i;
  logic                wbs_we_i;
  logic [WB_SEL_W-1:0] wbs_sel_i;
  logic [31:0]         wbs_adr_i;
  logic [WB_DAT_W-1:0] wbs_dat_i;
  logic                wbs_ack_o;
  logic [WB_DAT_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

`default_nettype wire

// File: rtl/wb_sram_responder.sv
// ------------------------------------------------------------------------------------
// wb_sram_responder : Wishbone responder driving port 0 of one sky130 1rw1r SRAM.  Rev 1.0
// ------------------------------------------------------------------------------------
`default_nettype none

module wb_sram_responder
  import rvj1_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH_WORDS = 9,
  parameter int unsigned READ_LATENCY     = 1
) (
  input  wire logic                        wb_clk_i,
  input  wire logic                        wb_rst_i,
  wb_sram_responder_if.slave               wbs,
  output logic                             sram_clk0,
  output logic                             sram_csb0,
  output logic                             sram_web0,
  output logic [SRAM_WMASK_W-1:0]          sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0]      sram_addr0,
  output logic [WB_DAT_W-1:0]              sram_din0,
  input  wire logic [WB_DAT_W-1:0]         sram_dout0
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  state_e                        state_q, state_d;
  logic                          ack_q, ack_d;
  logic [WB_DAT_W-1:0]           dat_q, dat_d;
  logic                          csb_q, csb_d;
  logic                          web_q, web_d;
  logic [SRAM_WMASK_W-1:0]       wmask_q, wmask_d;
  logic [ADDR_WIDTH_WORDS-1:0]   addr_q, addr_d;
  logic [WB_DAT_W-1:0]           din_q, din_d;
  logic [1:0]                    lat_q, lat_d;

  logic request;
  logic hit;
  logic needs_sram;
  logic unused_adr_lsb;

  assign request        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign hit            = window_hit(wbs.wbs_adr_i, BASE_ADDR, ADDR_WIDTH_WORDS + 2);
  // A write with no lanes selected is acknowledged without touching the macro.
  assign needs_sram     = hit & (~wbs.wbs_we_i | (|wbs.wbs_sel_i));
  assign unused_adr_lsb = ^wbs.wbs_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    lat_d   = lat_q;

    unique case (state_q)
      IDLE: begin
        if (request) begin
          if (needs_sram) begin
            addr_d  = wbs.wbs_adr_i[ADDR_WIDTH_WORDS+1:2];
            din_d   = wbs.wbs_dat_i;
            wmask_d = wbs.wbs_sel_i;
            web_d   = ~wbs.wbs_we_i;
            csb_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            ack_d   = 1'b1;
            dat_d   = MISS_RDATA;
            state_d = ACK;
          end
        end
      end
      ACCESS: begin
        lat_d = 2'd0;
        // Strobe is already issued, so a write aborted here still lands in the macro.
        if (!wbs.wbs_cyc_i) begin
          state_d = IDLE;
        end else if (!web_q) begin
          ack_d   = 1'b1;
          dat_d   = MISS_RDATA;
          state_d = ACK;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          ack_d   = 1'b1;
          dat_d   = sram_dout0;
          state_d = ACK;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ACK: begin
        dat_d   = MISS_RDATA;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      lat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      lat_q   <= lat_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign sram_clk0     = wb_clk_i;
  assign sram_csb0     = csb_q;
  assign sram_web0     = web_q;
  assign sram_wmask0   = wmask_q;
  assign sram_addr0    = addr_q;
  assign sram_din0     = din_q;

endmodule

`default_nettype wire
